// File: rtl/rnn_pkg.sv
// rtl/rnn_pkg.sv - shared RNN constants and stream state encoding; RESULT_STREAMER_SAT_EN selects clamp narrowing
package rnn_pkg;
    localparam int RNN_M      = 4;
    localparam int RNN_BW     = 16;
    localparam int RNN_BW_OUT = 32;
    localparam int RNN_FRAC   = 8;

`ifdef RESULT_STREAMER_SAT_EN
    localparam bit NARROW_SAT_EN = 1'b1;
`else
    localparam bit NARROW_SAT_EN = 1'b0;
`endif

    typedef enum logic {IDLE, STREAM} stream_state_t;
endpackage

// File: rtl/fx_narrow.sv
// rtl/fx_narrow.sv - fixed-point floor shift and narrow; clamps when RESULT_STREAMER_SAT_EN, else wraps
module fx_narrow
    import rnn_pkg::*;
#(
    parameter int BW_IN = RNN_BW_OUT,
    parameter int BW    = RNN_BW,
    parameter int FRAC  = RNN_FRAC
) (
    input  logic [BW_IN-1:0] din,
    output logic [BW-1:0]    dout,
    output logic             sat
);
    logic signed [BW_IN-1:0] s;
    logic                    ovf;

    assign s = $signed(din) >>> FRAC;
    // s fits in BW bits only when every bit from the narrowed sign bit upward agrees
    assign ovf = !((&s[BW_IN-1:BW-1]) || !(|s[BW_IN-1:BW-1]));
    assign sat = NARROW_SAT_EN && ovf;

    always_comb begin
        dout = s[BW-1:0];
        if (sat) begin
            dout = s[BW_IN-1] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
        end
    end
endmodule

// File: rtl/vector_result_streamer.sv
// rtl/vector_result_streamer.sv - captures a packed result vector and streams narrowed elements; RESULT_STREAMER_SAT_EN enables clamping
module vector_result_streamer
    import rnn_pkg::*;
#(
    parameter int M      = RNN_M,
    parameter int BW     = RNN_BW,
    parameter int BW_OUT = RNN_BW_OUT,
    parameter int FRAC   = RNN_FRAC,
    localparam int IDXW  = (M > 1) ? $clog2(M) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [M*BW_OUT-1:0] in_bus,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BW-1:0]       out_data,
    output logic [IDXW-1:0]     out_idx,
    output logic                out_last,
    output logic                busy,
    output logic                sat_flag
);
    stream_state_t     state;
    logic [BW_OUT-1:0] vbuf [M];
    logic [IDXW-1:0]   idx;
    logic [BW-1:0]     narrow_data;
    logic              narrow_sat;
    logic              last_idx;

    assign last_idx = (idx == IDXW'(M - 1));

    fx_narrow #(
        .BW_IN (BW_OUT),
        .BW    (BW),
        .FRAC  (FRAC)
    ) u_narrow (
        .din  (vbuf[idx]),
        .dout (narrow_data),
        .sat  (narrow_sat)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign out_data  = out_valid ? narrow_data : '0;
    assign out_idx   = idx;
    assign out_last  = out_valid && last_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            sat_flag <= 1'b0;
            for (int k = 0; k < M; k++) begin
                vbuf[k] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // element 0 sits in the most significant slot of the bus
                        for (int k = 0; k < M; k++) begin
                            vbuf[k] <= in_bus[(M-1-k)*BW_OUT +: BW_OUT];
                        end
                        idx      <= '0;
                        sat_flag <= 1'b0;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_ready) begin
                        if (narrow_sat) begin
                            sat_flag <= 1'b1;
                        end
                        if (last_idx) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
